kick_request_arbiter: RTL and testbench
=======================================

// Module: kick_request_arbiter
// PURPOSE
//  Shares the single ball-kick resource between N rod/key requesters. Latches each key-release
//  event as a pending kick request, grants at most one kick per video frame in round-robin order,
//  and enforces a per-requester cooldown counted in one-second ticks. Sits between the per-key
//  release detectors and the ball-motion logic, which asserts kickBusy while a kick is animating.
// PARAMETERS
//  NUM_REQ        4   number of requesters (keys/rods), 2..8
//  COOLDOWN_SEC   2   one-second ticks a requester is blocked after a grant, 0..15 (0 = none)
//  MAX_PEND_FRM   30  frames a pending request survives ungranted before it is dropped, 1..255
// PORTS
//  clk            in   1        system clock
//  resetN         in   1        asynchronous active-low reset
//  startOfFrame   in   1        one-cycle pulse per frame; the arbitration instant
//  oneSecCounter  in   1        one-cycle pulse per second; cooldown decrement tick
//  keyReleased    in   NUM_REQ  level per requester from release detectors; rising edge = request
//  kickBusy       in   1        kick resource occupied; no grant issued while high
//  grant          out  NUM_REQ  one-hot, one-cycle grant pulse
//  grantValid     out  1        high in the same cycle as any grant bit
//  grantIdx       out  3        binary index of granted requester, held until next grant
//  pending        out  NUM_REQ  current pending-request vector (status/debug)
//  coolingDown    out  NUM_REQ  requester i blocked by cooldown (status/debug)
// BEHAVIOUR
//  - Reset (async, any time incl. mid-operation): grant=0, grantValid=0, grantIdx=0, pending=0,
//    coolingDown=0, all cooldown/age counters=0, rr pointer=0, edge-detect history=0.
//  - Request capture: rising edge of keyReleased[i] (registered history) sets pending[i] next cycle
//    unless coolingDown[i]=1 or pending[i] already 1; such edges are discarded, not queued.
//  - Aging: on each startOfFrame with no grant to i, age[i]++ while pending[i]; when age[i] reaches
//    MAX_PEND_FRM, pending[i] clears. age[i] zeroes whenever pending[i] is set or cleared.
//  - Arbitration: evaluated only in the startOfFrame cycle, only if kickBusy=0 and pending!=0.
//    Winner = first set pending bit at or after rr pointer, wrapping NUM_REQ-1 -> 0.
//    Latency: grant/grantValid pulse exactly one cycle after the startOfFrame cycle, for one cycle.
//  - On grant to i: pending[i] clears, cooldown[i] loads COOLDOWN_SEC (coolingDown[i]=1 if >0),
//    rr pointer <= (i+1) mod NUM_REQ, grantIdx <= i.
//  - kickBusy=1 at startOfFrame: no grant, pointer unchanged, pending held (aging still applies).
//  - Cooldown: each oneSecCounter pulse decrements every nonzero cooldown; coolingDown[i] drops the
//    cycle the counter reaches 0. First tick may be partial second (no phase alignment).
//  - Simultaneous events: edge on i in the grant cycle of i -> discarded (cooldown wins);
//    edge on i in its aging-drop cycle -> pending stays 1, age restarts; oneSecCounter and grant load
//    in same cycle -> load wins (full COOLDOWN_SEC). Counters saturate, never wrap.
//  - At most one grant bit ever high; grant never issued outside the cycle after startOfFrame.
// STRUCTURE
//  - Package kick_arb_pkg: NUM_REQ_MAX=8, typedef logic [2:0] req_idx_t, typedef logic [3:0]
//    cool_cnt_t, typedef logic [7:0] age_cnt_t.
//  - Sub-module rr_priority_picker (combinational): inputs req vector + pointer, outputs one-hot
//    winner, index, any. Everything else (edge detect, pending, aging, cooldown, grant regs) here.
// TESTING
//  1. Reset mid-cooldown: grant req1, assert resetN=0 -> all outputs 0; after release req1 grantable.
//  2. Round-robin: keyReleased 4'b1111 edges together -> grants over 4 frames idx 0,1,2,3, one/frame.
//  3. Cooldown COOLDOWN_SEC=2: grant req2, re-press next frame -> ignored; after 2 oneSecCounter
//     pulses re-press -> pending[2]=1, granted at next frame.
//  4. kickBusy=1 for 3 frames with pending=4'b0100 -> no grant; kickBusy=0 -> grant=4'b0100 on
//     cycle after next startOfFrame.
//  5. Aging MAX_PEND_FRM=3, kickBusy held high: pending[0] clears after 3rd startOfFrame; no grant.
//  6. Edge on req1 in same cycle as grant to req1 -> pending[1]=0, coolingDown[1]=1 afterwards.

Source files
------------

// File: rtl/kick_arb_pkg.sv
// Shared types and limits for the kick request arbiter and its priority picker.
package kick_arb_pkg;

    localparam int NUM_REQ_MAX = 8;

    typedef logic [2:0] req_idx_t;
    typedef logic [3:0] cool_cnt_t;
    typedef logic [7:0] age_cnt_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping to 0.
module rr_priority_picker
    import kick_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
)
(
    input  logic [NUM_REQ-1:0] req,
    input  req_idx_t           ptr,
    output logic [NUM_REQ-1:0] winner,
    output req_idx_t           winIdx,
    output logic               any
);

    int cand;

    // Walk offsets from farthest to nearest so the nearest set request overwrites the others.
    always_comb begin
        winner = '0;
        winIdx = '0;
        cand   = 0;
        any    = |req;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = (int'(ptr) + k) % NUM_REQ;
            if (req[cand]) begin
                winner       = '0;
                winner[cand] = 1'b1;
                winIdx       = req_idx_t'(cand);
            end
        end
    end

endmodule

// File: rtl/kick_request_arbiter.sv
// Latches key-release requests, grants one kick per frame round-robin, and applies
// per-requester cooldown (in second ticks) and pending-request aging (in frames).
module kick_request_arbiter
    import kick_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int COOLDOWN_SEC = 2,
    parameter int MAX_PEND_FRM = 30
)
(
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               oneSecCounter,
    input  logic [NUM_REQ-1:0] keyReleased,
    input  logic               kickBusy,
    output logic [NUM_REQ-1:0] grant,
    output logic               grantValid,
    output req_idx_t           grantIdx,
    output logic [NUM_REQ-1:0] pending,
    output logic [NUM_REQ-1:0] coolingDown
);

    localparam age_cnt_t  AGE_LAST  = age_cnt_t'(MAX_PEND_FRM - 1);
    localparam cool_cnt_t COOL_LOAD = cool_cnt_t'(COOLDOWN_SEC);

    logic [NUM_REQ-1:0] keyHist;
    logic [NUM_REQ-1:0] keyRise;
    logic [NUM_REQ-1:0] pendingReg;
    logic [NUM_REQ-1:0] pendingNext;
    logic [NUM_REQ-1:0] grantReg;
    logic [NUM_REQ-1:0] grantHit;
    logic [NUM_REQ-1:0] winOneHot;
    logic [NUM_REQ-1:0] dropNow;
    logic               grantValidReg;
    logic               winAny;
    logic               doGrant;
    req_idx_t           grantIdxReg;
    req_idx_t           rrPtr;
    req_idx_t           rrPtrNext;
    req_idx_t           winIdx;
    age_cnt_t           ageReg   [NUM_REQ];
    age_cnt_t           ageNext  [NUM_REQ];
    cool_cnt_t          coolReg  [NUM_REQ];
    cool_cnt_t          coolNext [NUM_REQ];

    rr_priority_picker #(.NUM_REQ(NUM_REQ)) picker (
        .req    (pendingReg),
        .ptr    (rrPtr),
        .winner (winOneHot),
        .winIdx (winIdx),
        .any    (winAny)
    );

    assign keyRise   = keyReleased & ~keyHist;
    assign doGrant   = startOfFrame & ~kickBusy & winAny;
    assign grantHit  = doGrant ? winOneHot : '0;
    assign rrPtrNext = (winIdx == req_idx_t'(NUM_REQ - 1)) ? '0 : winIdx + 1'b1;

    // A grant overrides everything for that requester: pending clears and cooldown reloads in full,
    // so a same-cycle second tick or key edge has no effect. An edge landing on the aging-drop
    // cycle re-arms the request with a fresh age.
    always_comb begin
        pendingNext = pendingReg;
        dropNow     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            ageNext[i]  = ageReg[i];
            coolNext[i] = coolReg[i];
            if (grantHit[i]) begin
                pendingNext[i] = 1'b0;
                ageNext[i]     = '0;
                coolNext[i]    = COOL_LOAD;
            end else begin
                if (oneSecCounter && coolReg[i] != '0)
                    coolNext[i] = coolReg[i] - 1'b1;
                if (startOfFrame && pendingReg[i]) begin
                    if (ageReg[i] >= AGE_LAST) begin
                        pendingNext[i] = 1'b0;
                        ageNext[i]     = '0;
                        dropNow[i]     = 1'b1;
                    end else begin
                        ageNext[i] = ageReg[i] + 1'b1;
                    end
                end
                if (keyRise[i] && coolReg[i] == '0 && (!pendingReg[i] || dropNow[i])) begin
                    pendingNext[i] = 1'b1;
                    ageNext[i]     = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            keyHist       <= '0;
            pendingReg    <= '0;
            grantReg      <= '0;
            grantValidReg <= 1'b0;
            grantIdxReg   <= '0;
            rrPtr         <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                ageReg[i]  <= '0;
                coolReg[i] <= '0;
            end
        end else begin
            keyHist       <= keyReleased;
            pendingReg    <= pendingNext;
            grantReg      <= grantHit;
            grantValidReg <= doGrant;
            if (doGrant) begin
                grantIdxReg <= winIdx;
                rrPtr       <= rrPtrNext;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                ageReg[i]  <= ageNext[i];
                coolReg[i] <= coolNext[i];
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : genCoolFlag
        assign coolingDown[gi] = (coolReg[gi] != '0);
    end

    assign grant      = grantReg;
    assign grantValid = grantValidReg;
    assign grantIdx   = grantIdxReg;
    assign pending    = pendingReg;

endmodule

// File: tb/tb_kick_request_arbiter.sv
// Scoreboard bench: stimulus queues expected grants, a negedge monitor pops and checks them.
module tb_kick_request_arbiter;

    logic       clk;
    logic       resetN;
    logic       startOfFrame;
    logic       oneSecCounter;
    logic [3:0] keyReleased;
    logic       kickBusy;
    logic [3:0] grant;
    logic       grantValid;
    logic [2:0] grantIdx;
    logic [3:0] pending;
    logic [3:0] coolingDown;

    typedef struct {
        logic [3:0] vec;
        logic [2:0] idx;
        int         cyc;
    } exp_t;

    exp_t expQ[$];
    int   checkCnt = 0;
    int   passCnt  = 0;
    int   cyc      = 0;

    kick_request_arbiter #(
        .NUM_REQ      (4),
        .COOLDOWN_SEC (2),
        .MAX_PEND_FRM (4)
    ) dut (
        .clk           (clk),
        .resetN        (resetN),
        .startOfFrame  (startOfFrame),
        .oneSecCounter (oneSecCounter),
        .keyReleased   (keyReleased),
        .kickBusy      (kickBusy),
        .grant         (grant),
        .grantValid    (grantValid),
        .grantIdx      (grantIdx),
        .pending       (pending),
        .coolingDown   (coolingDown)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checkCnt++;
        if (act === req) passCnt++;
        else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Monitor: every presented grant must match the oldest expectation, including its cycle.
    always @(negedge clk) begin
        if (resetN && (grantValid || grant != 4'b0)) begin
            chk("grantValid_vs_grant", {31'b0, grantValid}, {31'b0, (grant != 4'b0)});
            if (expQ.size() == 0) begin
                chk("unexpected_grant", {28'b0, grant}, 32'h0);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                $display("grant cycle=%0d vec=%b idx=%0d (expected vec=%b idx=%0d cycle=%0d)",
                         cyc, grant, grantIdx, e.vec, e.idx, e.cyc);
                chk("grant_vec", {28'b0, grant}, {28'b0, e.vec});
                chk("grant_idx", {29'b0, grantIdx}, {29'b0, e.idx});
                chk("grant_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic checkIdle(input string tag);
        chk({tag, "_grant"}, {28'b0, grant}, 32'h0);
        chk({tag, "_grantValid"}, {31'b0, grantValid}, 32'h0);
        chk({tag, "_grantIdx"}, {29'b0, grantIdx}, 32'h0);
        chk({tag, "_pending"}, {28'b0, pending}, 32'h0);
        chk({tag, "_coolingDown"}, {28'b0, coolingDown}, 32'h0);
    endtask

    task automatic pulse(input logic [3:0] mask);
        @(negedge clk) keyReleased = mask;
        @(negedge clk) keyReleased = 4'b0;
        $display("keys %b -> pending=%b coolingDown=%b", mask, pending, coolingDown);
    endtask

    task automatic sof(input logic busy, input logic expGrant,
                       input logic [3:0] vec, input logic [2:0] idx);
        @(negedge clk);
        startOfFrame = 1'b1;
        kickBusy     = busy;
        if (expGrant) expQ.push_back('{vec: vec, idx: idx, cyc: cyc + 1});
        @(negedge clk) startOfFrame = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk) oneSecCounter = 1'b1;
        @(negedge clk) oneSecCounter = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetN = 1'b0; startOfFrame = 1'b0; oneSecCounter = 1'b0;
        keyReleased = 4'b0; kickBusy = 1'b0;
        repeat (3) @(negedge clk);
        checkIdle("reset");
        resetN = 1'b1;
        repeat (2) @(negedge clk);

        // Round-robin: all four requests together, one grant per frame in order 0..3.
        pulse(4'b1111);
        chk("rr_pending", {28'b0, pending}, 32'hF);
        sof(1'b0, 1'b1, 4'b0001, 3'd0);
        sof(1'b0, 1'b1, 4'b0010, 3'd1);
        sof(1'b0, 1'b1, 4'b0100, 3'd2);
        sof(1'b0, 1'b1, 4'b1000, 3'd3);
        chk("rr_pending_empty", {28'b0, pending}, 32'h0);
        chk("rr_cooling_all", {28'b0, coolingDown}, 32'hF);
        sof(1'b0, 1'b0, 4'b0, 3'd0);
        tick();
        chk("rr_cool_after_1tick", {28'b0, coolingDown}, 32'hF);
        tick();
        chk("rr_cool_after_2tick", {28'b0, coolingDown}, 32'h0);

        // Reset in the middle of a cooldown, then the same requester is grantable again.
        pulse(4'b0010);
        sof(1'b0, 1'b1, 4'b0010, 3'd1);
        chk("rst_mid_cooling", {28'b0, coolingDown}, 32'h2);
        @(negedge clk) resetN = 1'b0;
        #1;
        checkIdle("rst_mid");
        @(negedge clk) resetN = 1'b1;
        pulse(4'b0010);
        chk("rst_after_pending", {28'b0, pending}, 32'h2);
        sof(1'b0, 1'b1, 4'b0010, 3'd1);
        tick(); tick();

        // Cooldown: re-press during cooldown is discarded, accepted after two ticks.
        pulse(4'b0100);
        sof(1'b0, 1'b1, 4'b0100, 3'd2);
        pulse(4'b0100);
        chk("cool_repress_ignored", {28'b0, pending}, 32'h0);
        chk("cool_flag_set", {28'b0, coolingDown}, 32'h4);
        sof(1'b0, 1'b0, 4'b0, 3'd0);
        tick();
        chk("cool_flag_1tick", {28'b0, coolingDown}, 32'h4);
        tick();
        chk("cool_flag_cleared", {28'b0, coolingDown}, 32'h0);
        pulse(4'b0100);
        chk("cool_repress_taken", {28'b0, pending}, 32'h4);
        sof(1'b0, 1'b1, 4'b0100, 3'd2);
        tick(); tick();

        // Edge on req1 in the very cycle req1's grant is presented: discarded.
        pulse(4'b0010);
        @(negedge clk);
        startOfFrame = 1'b1;
        expQ.push_back('{vec: 4'b0010, idx: 3'd1, cyc: cyc + 1});
        @(negedge clk);
        startOfFrame = 1'b0;
        keyReleased  = 4'b0010;
        @(negedge clk) keyReleased = 4'b0;
        @(negedge clk);
        chk("same_cycle_pending", {28'b0, pending}, 32'h0);
        chk("same_cycle_cooling", {28'b0, coolingDown}, 32'h2);
        tick(); tick();

        // kickBusy holds off the grant for three frames, then it issues normally.
        pulse(4'b0100);
        sof(1'b1, 1'b0, 4'b0, 3'd0);
        sof(1'b1, 1'b0, 4'b0, 3'd0);
        sof(1'b1, 1'b0, 4'b0, 3'd0);
        chk("busy_pending_held", {28'b0, pending}, 32'h4);
        sof(1'b0, 1'b1, 4'b0100, 3'd2);
        repeat (3) @(negedge clk);
        chk("busy_grantIdx_held", {29'b0, grantIdx}, 32'h2);
        tick(); tick();

        // Aging (4 frames here) under a held kickBusy: request dropped, no grant.
        pulse(4'b0001);
        repeat (3) sof(1'b1, 1'b0, 4'b0, 3'd0);
        chk("age_pending_3frm", {28'b0, pending}, 32'h1);
        sof(1'b1, 1'b0, 4'b0, 3'd0);
        chk("age_dropped", {28'b0, pending}, 32'h0);

        // Edge on the drop frame keeps the request alive with a fresh age.
        pulse(4'b1000);
        repeat (3) sof(1'b1, 1'b0, 4'b0, 3'd0);
        @(negedge clk);
        startOfFrame = 1'b1;
        keyReleased  = 4'b1000;
        @(negedge clk);
        startOfFrame = 1'b0;
        keyReleased  = 4'b0;
        chk("age_rearm_pending", {28'b0, pending}, 32'h8);
        repeat (3) sof(1'b1, 1'b0, 4'b0, 3'd0);
        chk("age_rearm_3frm", {28'b0, pending}, 32'h8);
        sof(1'b1, 1'b0, 4'b0, 3'd0);
        chk("age_rearm_dropped", {28'b0, pending}, 32'h0);
        sof(1'b0, 1'b0, 4'b0, 3'd0);
        repeat (3) @(negedge clk);

        chk("queue_drained", expQ.size(), 32'h0);
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
